// File: rtl/seq_detector_param_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_detector_param_pkg;

  // Meaning of the overlap input when the detector leaves the MATCH state
  typedef enum logic {
    OVERLAP_OFF = 1'b0,
    OVERLAP_ON  = 1'b1
  } overlap_e;

  // What the detector does with the current cycle
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_SAMPLE = 2'd1,
    ACT_LOAD   = 2'd2
  } action_e;

  localparam int              DEFAULT_PAT_LEN = 4;
  localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 4'b1000;

  // Width needed to hold a prefix length from 0 up to and including patLen
  function automatic int stateWidth(input int patLen);
    return $clog2(patLen + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] r_count;

  // Count up on inc, stick at the maximum value, clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX_COUNT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign q = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with parallel Mealy and Moore outputs driven from one
// prefix-tracking state, a runtime-loadable pattern and a saturating match counter.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic               load_pat,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clear_cnt,
  output logic               mealy_out,
  output logic               moore_out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int              ST_W     = stateWidth(PAT_LEN);
  localparam logic [ST_W-1:0] MATCH_ST = ST_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-2:0] r_hist;
  logic [ST_W-1:0]    r_state;
  logic               r_moore;

  logic [PAT_LEN-1:0] w_window;
  logic [ST_W-1:0]    w_nextState;
  logic               w_overlapOn;
  logic               w_mealy;
  action_e            w_action;

  // Longest pattern prefix that is a suffix of the supported history plus the new bit.
  // Only the last s+1 bits of the window are backed by the current state, so k is
  // bounded by that; from MATCH the whole pattern backs the window when overlapping,
  // otherwise the new bit is judged as if nothing had been matched.
  function automatic logic [ST_W-1:0] nextState(
    input logic [ST_W-1:0]    s,
    input logic [PAT_LEN-1:0] window,
    input logic [PAT_LEN-1:0] pat,
    input logic               ovl
  );
    int          limit;
    int          best;
    logic [31:0] mask;
    logic [31:0] win32;
    logic [31:0] pre32;
    if (s == MATCH_ST) begin
      limit = ovl ? PAT_LEN : 1;
    end else begin
      limit = int'(s) + 1;
    end
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      mask  = (32'd1 << k) - 32'd1;
      win32 = 32'(window) & mask;
      pre32 = (32'(pat) >> (PAT_LEN - k)) & mask;
      if ((k <= limit) && (win32 == pre32)) begin
        best = k;
      end
    end
    return ST_W'(best);
  endfunction

  assign w_window    = {r_hist, x};
  assign w_overlapOn = (overlap_e'(overlap) == OVERLAP_ON);
  assign w_nextState = nextState(r_state, w_window, r_pat, w_overlapOn);

  // Decide whether this cycle loads a pattern, consumes x, or leaves state alone
  always_comb begin
    w_action = ACT_HOLD;
    if (load_pat) begin
      w_action = ACT_LOAD;
    end else if (en) begin
      w_action = ACT_SAMPLE;
    end
  end

  assign w_mealy = (w_action == ACT_SAMPLE) && (w_nextState == MATCH_ST);

  // Prefix-tracking FSM: pattern register, bit history, state and registered Moore flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat   <= PATTERN;
      r_hist  <= '0;
      r_state <= '0;
      r_moore <= 1'b0;
    end else begin
      case (w_action)
        ACT_LOAD: begin
          r_pat   <= pat_in;
          r_state <= '0;
          r_moore <= 1'b0;
        end
        ACT_SAMPLE: begin
          r_hist  <= w_window[PAT_LEN-2:0];
          r_state <= w_nextState;
          r_moore <= w_mealy;
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_matchCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_mealy),
    .clr   (clear_cnt),
    .q     (match_cnt)
  );

  assign mealy_out = w_mealy;
  assign moore_out = r_moore;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a stream model.
module tb_seq_detector_param;

  localparam int PAT_LEN = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         x;
  logic         overlap;
  logic         loadPat;
  logic [3:0]   patIn;
  logic         clearCnt;
  logic         mealyOut;
  logic         mooreOut;
  logic [7:0]   matchCnt;
  logic         mealyOut2;
  logic         mooreOut2;
  logic [1:0]   matchCnt2;

  int checks   = 0;
  int failures = 0;

  logic        obsMealy;
  logic [15:0] seen;

  // Reference model state: the bit stream since the last restart point
  logic [3:0]  mPat;
  logic [63:0] mHist;
  int          mLen;
  int          mS;
  int          mCnt;
  int          mCnt2;

  seq_detector_param #(
    .PAT_LEN(4),
    .PATTERN(4'b1000),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .x         (x),
    .overlap   (overlap),
    .load_pat  (loadPat),
    .pat_in    (patIn),
    .clear_cnt (clearCnt),
    .mealy_out (mealyOut),
    .moore_out (mooreOut),
    .match_cnt (matchCnt)
  );

  seq_detector_param #(
    .PAT_LEN(4),
    .PATTERN(4'b1000),
    .CNT_W(2)
  ) dutSmall (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .x         (x),
    .overlap   (overlap),
    .load_pat  (loadPat),
    .pat_in    (patIn),
    .clear_cnt (clearCnt),
    .mealy_out (mealyOut2),
    .moore_out (mooreOut2),
    .match_cnt (matchCnt2)
  );

  always #5 clk = ~clk;

  // Record one comparison and report it if it disagrees
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Longest prefix of p that ends the stream (newest bit at index 0)
  function automatic int longestPrefix(input logic [63:0] bits, input int len, input logic [3:0] p);
    int best;
    int lim;
    bit ok;
    best = 0;
    lim  = (len < PAT_LEN) ? len : PAT_LEN;
    for (int k = 1; k <= lim; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (bits[i] != p[PAT_LEN-k+i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Stream after consuming xb, and the matched prefix length it yields
  function automatic void advance(input logic xb, input logic ovl, output int nxt,
                                  output logic [63:0] bits, output int len);
    bits = mHist;
    len  = mLen;
    if ((mS == PAT_LEN) && !ovl) begin
      bits = '0;
      len  = 0;
    end
    bits = {bits[62:0], xb};
    len  = (len < 63) ? len + 1 : 63;
    nxt  = longestPrefix(bits, len, mPat);
  endfunction

  // Advance the reference model on every rising edge
  always @(posedge clk) begin
    int          nxt;
    logic [63:0] b;
    int          l;
    bit          expMealy;
    if (reset) begin
      mPat  = 4'b1000;
      mHist = '0;
      mLen  = 0;
      mS    = 0;
      mCnt  = 0;
      mCnt2 = 0;
    end else begin
      advance(x, overlap, nxt, b, l);
      expMealy = en && !loadPat && (nxt == PAT_LEN);
      if (clearCnt) begin
        mCnt  = 0;
        mCnt2 = 0;
      end else if (expMealy) begin
        mCnt  = (mCnt < 255) ? mCnt + 1 : 255;
        mCnt2 = (mCnt2 < 3) ? mCnt2 + 1 : 3;
      end
      if (loadPat) begin
        mPat  = patIn;
        mHist = '0;
        mLen  = 0;
        mS    = 0;
      end else if (en) begin
        mHist = b;
        mLen  = l;
        mS    = nxt;
      end
    end
  end

  // Compare both instances against the model in the middle of every cycle
  always @(negedge clk) begin
    int          nxt;
    logic [63:0] b;
    int          l;
    int          expMealy;
    if (!reset) begin
      advance(x, overlap, nxt, b, l);
      expMealy = (en && !loadPat && (nxt == PAT_LEN)) ? 1 : 0;
      checkOutput("model_mealy", int'(mealyOut), expMealy);
      checkOutput("model_moore", int'(mooreOut), (mS == PAT_LEN) ? 1 : 0);
      checkOutput("model_cnt", int'(matchCnt), mCnt);
      checkOutput("model_mealy_w2", int'(mealyOut2), expMealy);
      checkOutput("model_moore_w2", int'(mooreOut2), (mS == PAT_LEN) ? 1 : 0);
      checkOutput("model_cnt_w2", int'(matchCnt2), mCnt2);
    end
  end

  // Drive one cycle of inputs and capture the Mealy output mid-cycle
  task automatic applyStimulus(input logic e, input logic xb, input logic ovl,
                               input logic ld, input logic [3:0] p, input logic clr);
    en       = e;
    x        = xb;
    overlap  = ovl;
    loadPat  = ld;
    patIn    = p;
    clearCnt = clr;
    @(negedge clk);
    #1;
    obsMealy = mealyOut;
    @(posedge clk);
    #1;
  endtask

  // Send n bits, first bit taken from position n-1; seen[i] is mealy on sample i
  task automatic sendBits(input logic [15:0] bits, input int n, input logic ovl);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, bits[n-1-i], ovl, 1'b0, 4'b0000, 1'b0);
      seen[i] = obsMealy;
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    x        = 1'b0;
    overlap  = 1'b1;
    loadPat  = 1'b0;
    patIn    = 4'b0000;
    clearCnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_moore", int'(mooreOut), 0);
    checkOutput("reset_mealy", int'(mealyOut), 0);
    checkOutput("reset_cnt", int'(matchCnt), 0);

    // Default pattern 1000 then 1011
    sendBits(16'b1000, 4, 1'b1);
    checkOutput("t1_mealy_seq", int'(seen), 16'h0008);
    checkOutput("t1_moore_after", int'(mooreOut), 1);
    sendBits(16'b1011, 4, 1'b1);
    checkOutput("t1_mealy_tail", int'(seen), 0);
    checkOutput("t1_cnt", int'(matchCnt), 1);

    // Pattern 1010 with and without overlap
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);
    checkOutput("t2_load_mealy", int'(obsMealy), 0);
    sendBits(16'b101010, 6, 1'b1);
    checkOutput("t2_overlap_seq", int'(seen), 16'h0028);
    checkOutput("t2_overlap_cnt", int'(matchCnt), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
    sendBits(16'b101010, 6, 1'b0);
    checkOutput("t2_nonoverlap_seq", int'(seen), 16'h0008);
    checkOutput("t2_nonoverlap_cnt", int'(matchCnt), 4);
    checkOutput("t2_cnt_w2", int'(matchCnt2), 3);

    // Fallback from a repeated leading 1
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0);
    sendBits(16'b11000, 5, 1'b1);
    checkOutput("t3_fallback_seq", int'(seen), 16'h0010);
    checkOutput("t3_cnt", int'(matchCnt), 5);

    // Sample-enable gaps
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      checkOutput("t4_gap_mealy", int'(obsMealy), 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    checkOutput("t4_pre_mealy", int'(obsMealy), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    checkOutput("t4_match_mealy", int'(obsMealy), 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      checkOutput("t4_hold_moore", int'(mooreOut), 1);
      checkOutput("t4_hold_mealy", int'(obsMealy), 0);
    end
    checkOutput("t4_cnt", int'(matchCnt), 6);

    // Saturation of the narrow counter and clear priority
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    checkOutput("t5_clear_cnt", int'(matchCnt), 0);
    checkOutput("t5_clear_cnt_w2", int'(matchCnt2), 0);
    for (int i = 0; i < 5; i++) sendBits(16'b1000, 4, 1'b1);
    checkOutput("t5_sat_cnt_w2", int'(matchCnt2), 3);
    checkOutput("t5_cnt", int'(matchCnt), 5);
    sendBits(16'b100, 3, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    checkOutput("t5_clr_match_mealy", int'(obsMealy), 1);
    checkOutput("t5_clr_wins_cnt", int'(matchCnt), 0);
    checkOutput("t5_clr_wins_cnt_w2", int'(matchCnt2), 0);

    // Asynchronous reset mid-cycle restores the reset pattern
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);
    sendBits(16'b1010, 4, 1'b1);
    checkOutput("t6_pre_moore", int'(mooreOut), 1);
    checkOutput("t6_pre_cnt", int'(matchCnt), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_moore", int'(mooreOut), 0);
    checkOutput("t6_async_cnt", int'(matchCnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sendBits(16'b1000, 4, 1'b1);
    checkOutput("t6_after_reset_seq", int'(seen), 16'h0008);
    checkOutput("t6_after_reset_cnt", int'(matchCnt), 1);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(1)),
                    1'($urandom_range(1)),
                    ($urandom_range(31) == 0) ? 1'b1 : 1'b0,
                    4'($urandom_range(15)),
                    ($urandom_range(31) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
